// File: rtl/npu_inst_pkg.sv
// Shared opcode, error-code and FSM-state definitions for the NPU instruction sequencer.
package npu_inst_pkg;

  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_HALT = 1;
  localparam int unsigned OP_SYNC = 2;
  localparam int unsigned OP_EXEC = 3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_PC_OVF  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StSync,
    StFinish
  } seq_state_e;

endpackage

// File: rtl/inst_decoder.sv
// Combinational instruction field extraction and opcode legality check.
module inst_decoder
  import npu_inst_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 4,
  parameter int unsigned UNIT_W   = 2
) (
  input  logic [OP_WIDTH+UNIT_W-1:0] inst_hi,
  output logic                       is_nop,
  output logic                       is_halt,
  output logic                       is_sync,
  output logic                       is_exec,
  output logic                       illegal,
  output logic [UNIT_W-1:0]          unit
);

  logic [OP_WIDTH-1:0] op;

  assign op   = inst_hi[OP_WIDTH+UNIT_W-1 -: OP_WIDTH];
  assign unit = inst_hi[UNIT_W-1:0];

  // NUM_UNITS is a power of two, so every UNIT_W-bit index names a real unit;
  // only the opcode can make an instruction illegal.
  always_comb begin
    is_nop  = (op == OP_WIDTH'(OP_NOP));
    is_halt = (op == OP_WIDTH'(OP_HALT));
    is_sync = (op == OP_WIDTH'(OP_SYNC));
    is_exec = (op == OP_WIDTH'(OP_EXEC));
    illegal = !(is_nop || is_halt || is_sync || is_exec);
  end

endmodule

// File: rtl/inst_sequencer.sv
// NPU instruction sequencer: fetch/decode/dispatch FSM owning the program counter.
// Optional ISSUE/SYNC watchdog is compiled in with `define INST_SEQ_TIMEOUT_EN.
module inst_sequencer
  import npu_inst_pkg::*;
#(
  parameter int unsigned INST_LEN       = 16,
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned OP_WIDTH       = 4,
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  start_pc,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err_code,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 imem_en,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [INST_LEN-1:0]  imem_data,
  output logic [NUM_UNITS-1:0] issue_valid,
  input  logic [NUM_UNITS-1:0] issue_ready,
  output logic [INST_LEN-1:0]  issue_inst,
  input  logic [NUM_UNITS-1:0] unit_busy
);

  localparam int unsigned UNIT_W = $clog2(NUM_UNITS);
  localparam logic [PC_WIDTH-1:0] PC_MAX = '1;

  seq_state_e state;

  logic              dec_nop;
  logic              dec_halt;
  logic              dec_sync;
  logic              dec_exec;
  logic              dec_illegal;
  logic [UNIT_W-1:0] dec_unit;
  logic              issue_done;
  logic              advance;
  logic              wd_expired;

  inst_decoder #(
    .OP_WIDTH (OP_WIDTH),
    .UNIT_W   (UNIT_W)
  ) u_decoder (
    .inst_hi (imem_data[INST_LEN-1 -: OP_WIDTH+UNIT_W]),
    .is_nop  (dec_nop),
    .is_halt (dec_halt),
    .is_sync (dec_sync),
    .is_exec (dec_exec),
    .illegal (dec_illegal),
    .unit    (dec_unit)
  );

  assign imem_addr  = pc;
  assign issue_done = |(issue_valid & issue_ready);

  // Every path that moves on to the next instruction funnels through one PC-advance step.
  assign advance = (state == StDecode && dec_nop) ||
                   (state == StIssue  && issue_done) ||
                   (state == StSync   && unit_busy == '0);

`ifdef INST_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // ISSUE and SYNC are only entered from DECODE, so clearing outside them restarts it on entry.
  always_ff @(posedge clk) begin
    if (rst || !(state == StIssue || state == StSync)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_code    <= ERR_NONE;
      pc          <= '0;
      imem_en     <= 1'b0;
      issue_valid <= '0;
      issue_inst  <= '0;
    end else begin
      done    <= 1'b0;
      imem_en <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            pc       <= start_pc;
            err_code <= ERR_NONE;
            busy     <= 1'b1;
            imem_en  <= 1'b1;
            state    <= StFetch;
          end
        end
        StFetch: state <= StDecode;
        StDecode: begin
          issue_inst <= imem_data;
          if (dec_illegal) begin
            if (err_code == ERR_NONE) err_code <= ERR_ILLEGAL;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StFinish;
          end else if (dec_exec) begin
            issue_valid <= NUM_UNITS'(1) << dec_unit;
            state       <= StIssue;
          end else if (dec_sync) begin
            state <= StSync;
          end else if (dec_halt) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StFinish;
          end
        end
        StIssue: begin
          if (issue_done) begin
            issue_valid <= '0;
          end else if (wd_expired) begin
            issue_valid <= '0;
            if (err_code == ERR_NONE) err_code <= ERR_TIMEOUT;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StFinish;
          end
        end
        StSync: begin
          if (unit_busy != '0 && wd_expired) begin
            if (err_code == ERR_NONE) err_code <= ERR_TIMEOUT;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StFinish;
          end
        end
        StFinish: state <= StIdle;
        default:  state <= StIdle;
      endcase

      // Stop at the top of the address space rather than wrapping to 0.
      if (advance) begin
        if (pc == PC_MAX) begin
          if (err_code == ERR_NONE) err_code <= ERR_PC_OVF;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StFinish;
        end else begin
          pc      <= pc + 1'b1;
          imem_en <= 1'b1;
          state   <= StFetch;
        end
      end
    end
  end

endmodule
